// File: rtl/usb_rx_decoder.sv
// USB receive front end: DPLL bit recovery, NRZI decode, SYNC/unstuff/EOP.
// Delivers bytes with strobes and keeps a 64-bit window of recent bytes.
module usb_rx_decoder #(
  parameter logic [15:0] FS_INC    = 16'd15729,
  parameter logic [15:0] LS_INC    = 16'd1966,
  parameter int          IDLE_BITS = 8
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic        iDP,
  input  logic        iDM,
  input  logic        iIS_FS,
  output logic [7:0]  oByte,
  output logic        oByte_valid,
  output logic        oPkt_start,
  output logic        oPkt_end,
  output logic        oErr,
  output logic [6:0]  oByte_cnt,
  output logic [63:0] oData,
  output logic [2:0]  oState
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    EOP  = 3'd3,
    ERRW = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  dp_s;
  logic [1:0]  dm_s;
  logic [1:0]  ln_q;
  logic [15:0] phase;
  logic        is_fs;
  logic        prev_j;
  logic        partial;
  logic [2:0]  cnt;
  logic [2:0]  ones;
  logic [7:0]  sh;
  logic [3:0]  jcnt;

  logic        dp;
  logic        dm;
  logic        j;
  logic        k;
  logic        se0;
  logic        se1;
  logic        chg;
  logic        clr;
  logic        stb;
  logic        bit_in;
  logic [15:0] inc;
  logic [15:0] nxt;
  logic [7:0]  sh_n;

  assign dp     = dp_s[1];
  assign dm     = dm_s[1];
  assign j      = is_fs ? (dp & ~dm) : (~dp & dm);
  assign k      = is_fs ? (~dp & dm) : (dp & ~dm);
  assign se0    = ~dp & ~dm;
  assign se1    = dp & dm;
  assign chg    = {dp, dm} != ln_q;
  assign clr    = chg | ((state == IDLE) & k);
  assign inc    = is_fs ? FS_INC : LS_INC;
  assign nxt    = phase + inc;
  // Mid-bit sample: phase crosses the half-way point this cycle
  assign stb    = ~clr & ~phase[15] & nxt[15];
  assign bit_in = (j == prev_j);
  assign sh_n   = {bit_in, sh[7:1]};
  assign oState = state;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      dp_s  <= '0;
      dm_s  <= '0;
      ln_q  <= '0;
      phase <= '0;
    end else begin
      dp_s  <= {dp_s[0], iDP};
      dm_s  <= {dm_s[0], iDM};
      ln_q  <= {dp, dm};
      phase <= clr ? 16'd0 : nxt;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state       <= IDLE;
      is_fs       <= 1'b0;
      prev_j      <= 1'b1;
      partial     <= 1'b0;
      cnt         <= '0;
      ones        <= '0;
      sh          <= '0;
      jcnt        <= '0;
      oByte       <= '0;
      oByte_valid <= 1'b0;
      oPkt_start  <= 1'b0;
      oPkt_end    <= 1'b0;
      oErr        <= 1'b0;
      oByte_cnt   <= '0;
      oData       <= '0;
    end else begin
      oByte_valid <= 1'b0;
      oPkt_start  <= 1'b0;
      oPkt_end    <= 1'b0;
      oErr        <= 1'b0;
      if (stb) prev_j <= j;
      unique case (state)
        IDLE: begin
          is_fs  <= iIS_FS;
          prev_j <= 1'b1;
          jcnt   <= '0;
          if (k) begin
            cnt   <= '0;
            state <= SYNC;
          end
        end
        SYNC: if (stb) begin
          if (se0 | se1) begin
            oErr  <= 1'b1;
            state <= ERRW;
          end else begin
            sh  <= sh_n;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sh_n == 8'h80) begin
                oPkt_start <= 1'b1;
                oByte_cnt  <= '0;
                ones       <= 3'd1;
                state      <= DATA;
              end else begin
                oErr  <= 1'b1;
                state <= ERRW;
              end
            end
          end
        end
        DATA: if (stb) begin
          if (se0) begin
            partial <= (cnt != 3'd0);
            state   <= EOP;
          end else if (se1) begin
            oErr  <= 1'b1;
            state <= ERRW;
          end else if (ones == 3'd6) begin
            // Stuffed bit: must be a 0 and is dropped
            if (bit_in) begin
              oErr  <= 1'b1;
              state <= ERRW;
            end else begin
              ones <= '0;
            end
          end else begin
            ones <= bit_in ? ones + 3'd1 : 3'd0;
            sh   <= sh_n;
            cnt  <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              oByte       <= sh_n;
              oData       <= {oData[55:0], sh_n};
              oByte_valid <= 1'b1;
              if (oByte_cnt != 7'd127) oByte_cnt <= oByte_cnt + 7'd1;
            end
          end
        end
        EOP: if (stb) begin
          if (j) begin
            oPkt_end <= 1'b1;
            oErr     <= partial;
            state    <= IDLE;
          end else if (k | se1) begin
            oErr  <= 1'b1;
            state <= ERRW;
          end
        end
        ERRW: begin
          if ((ln_q == 2'b00) && j) begin
            state <= IDLE;
          end else if (stb) begin
            if (j) begin
              jcnt <= jcnt + 4'd1;
              if (jcnt == 4'(IDLE_BITS - 1)) state <= IDLE;
            end else begin
              jcnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: builds NRZI line symbol streams
// and plays them on the pins in real time at FS or LS bit rates.
`timescale 1ns/1ps
module tb_usb_rx_decoder;

  logic        iCLK = 1'b0;
  logic        iRSTN;
  logic        iDP;
  logic        iDM;
  logic        iIS_FS;
  logic [7:0]  oByte;
  logic        oByte_valid;
  logic        oPkt_start;
  logic        oPkt_end;
  logic        oErr;
  logic [6:0]  oByte_cnt;
  logic [63:0] oData;
  logic [2:0]  oState;

  usb_rx_decoder dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iDP(iDP), .iDM(iDM),
    .iIS_FS(iIS_FS), .oByte(oByte), .oByte_valid(oByte_valid),
    .oPkt_start(oPkt_start), .oPkt_end(oPkt_end), .oErr(oErr),
    .oByte_cnt(oByte_cnt), .oData(oData), .oState(oState)
  );

  always #10 iCLK = ~iCLK;

  localparam logic [1:0] SJ = 2'd0;
  localparam logic [1:0] SK = 2'd1;
  localparam logic [1:0] S0 = 2'd2;

  int checks = 0;
  int failures = 0;
  int n_start, n_end, n_err, n_pair, n_overlap;
  int cyc = 0;
  int last_stb, sp_min, sp_max, sp_n;
  logic [7:0] got[$];
  logic [1:0] sym[$];
  bit  fs;
  real bit_ns;
  logic lvl;
  int  ones;

  always @(negedge iCLK) begin
    int n;
    cyc++;
    n = int'(oByte_valid) + int'(oPkt_start) + int'(oPkt_end) + int'(oErr);
    if (oByte_valid) got.push_back(oByte);
    if (oPkt_start) n_start++;
    if (oPkt_end) n_end++;
    if (oErr) n_err++;
    if (oErr && oPkt_end) n_pair++;
    if (n > 1 && !(n == 2 && oErr && oPkt_end)) n_overlap++;
    if (dut.stb && oState == 3'd1) begin
      if (last_stb >= 0) begin
        if (cyc - last_stb < sp_min) sp_min = cyc - last_stb;
        if (cyc - last_stb > sp_max) sp_max = cyc - last_stb;
        sp_n++;
      end
      last_stb = cyc;
    end
  end

  task automatic clear_mon();
    n_start = 0; n_end = 0; n_err = 0; n_pair = 0;
    got.delete();
    last_stb = -1; sp_min = 1000; sp_max = 0; sp_n = 0;
  endtask

  task automatic set_line(input logic [1:0] s);
    case (s)
      SJ:      {iDP, iDM} = fs ? 2'b10 : 2'b01;
      SK:      {iDP, iDM} = fs ? 2'b01 : 2'b10;
      default: {iDP, iDM} = 2'b00;
    endcase
  endtask

  task automatic add_nrzi(input logic b);
    if (!b) lvl = ~lvl;
    sym.push_back(lvl ? SJ : SK);
  endtask

  task automatic add_sync();
    lvl = 1'b1;
    for (int i = 0; i < 7; i++) add_nrzi(1'b0);
    add_nrzi(1'b1);
    ones = 1;
  endtask

  task automatic add_bit(input logic b, input logic force1);
    add_nrzi(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      add_nrzi(force1);
      ones = 0;
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input logic force1);
    for (int i = 0; i < 8; i++) add_bit(b[i], force1);
  endtask

  task automatic add_eop();
    sym.push_back(S0);
    sym.push_back(S0);
    sym.push_back(SJ);
    lvl = 1'b1;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) sym.push_back(SJ);
    lvl = 1'b1;
  endtask

  task automatic play();
    logic [1:0] s;
    while (sym.size() > 0) begin
      s = sym.pop_front();
      set_line(s);
      #(bit_ns);
    end
  endtask

  task automatic test_reset();
    iRSTN = 1'b0;
    set_line(SJ);
    #45;
    checks++; if (oState !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", oState); end
    checks++; if (oData !== 64'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", oData); end
    checks++; if ({oByte, oByte_cnt} !== 15'd0) begin failures++; $display("FAIL rst_byte got=%h/%0d exp=0/0", oByte, oByte_cnt); end
    checks++; if ({oByte_valid, oPkt_start, oPkt_end, oErr} !== 4'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {oByte_valid, oPkt_start, oPkt_end, oErr}); end
    iRSTN = 1'b1;
    add_idle(4);
    play();
  endtask

  task automatic test_fs_basic();
    clear_mon();
    add_sync(); add_byte(8'hA5, 1'b0); add_byte(8'hC3, 1'b0);
    add_eop(); add_idle(4);
    play();
    checks++; if (n_start !== 1) begin failures++; $display("FAIL basic_start got=%0d exp=1", n_start); end
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL basic_nbytes got=%0d exp=2", got.size()); end
    checks++; if (got[0] !== 8'hA5) begin failures++; $display("FAIL basic_byte0 got=%h exp=a5", got[0]); end
    checks++; if (got[1] !== 8'hC3) begin failures++; $display("FAIL basic_byte1 got=%h exp=c3", got[1]); end
    checks++; if (oData[15:0] !== 16'hA5C3) begin failures++; $display("FAIL basic_data got=%h exp=a5c3", oData[15:0]); end
    checks++; if (oByte_cnt !== 7'd2) begin failures++; $display("FAIL basic_cnt got=%0d exp=2", oByte_cnt); end
    checks++; if (n_end !== 1) begin failures++; $display("FAIL basic_end got=%0d exp=1", n_end); end
    checks++; if (n_err !== 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", n_err); end
    checks++; if (oState !== 3'd0) begin failures++; $display("FAIL basic_idle got=%0d exp=0", oState); end
  endtask

  task automatic test_stuff();
    clear_mon();
    add_sync(); add_byte(8'hFF, 1'b0); add_eop(); add_idle(4);
    play();
    checks++; if (got.size() !== 1 || got[0] !== 8'hFF) begin failures++; $display("FAIL stuff_byte got=%0d/%h exp=1/ff", got.size(), got[0]); end
    checks++; if (n_err !== 0 || n_end !== 1) begin failures++; $display("FAIL stuff_ok got err=%0d end=%0d exp 0/1", n_err, n_end); end
    clear_mon();
    add_sync(); add_byte(8'hFF, 1'b1);
    play();
    checks++; if (n_err !== 1) begin failures++; $display("FAIL stuffbad_err got=%0d exp=1", n_err); end
    checks++; if (oState !== 3'd4) begin failures++; $display("FAIL stuffbad_state got=%0d exp=4", oState); end
    add_idle(5);
    play();
    checks++; if (oState !== 3'd4) begin failures++; $display("FAIL stuffbad_wait got=%0d exp=4", oState); end
    add_idle(8);
    play();
    checks++; if (oState !== 3'd0) begin failures++; $display("FAIL stuffbad_recover got=%0d exp=0", oState); end
    checks++; if (got.size() !== 0 || n_start !== 1) begin failures++; $display("FAIL stuffbad_out got bytes=%0d start=%0d exp 0/1", got.size(), n_start); end
  endtask

  task automatic test_low_speed();
    set_line(S0);
    #200;
    iIS_FS = 1'b0; fs = 1'b0;
    #200;
    bit_ns = 1000.0 / 1.5;
    add_idle(3); play();
    clear_mon();
    add_sync(); add_byte(8'h2D, 1'b0); add_eop(); add_idle(3);
    play();
    checks++; if (got.size() !== 1 || got[0] !== 8'h2D) begin failures++; $display("FAIL ls_byte got=%0d/%h exp=1/2d", got.size(), got[0]); end
    checks++; if (n_err !== 0 || n_end !== 1) begin failures++; $display("FAIL ls_end got err=%0d end=%0d exp 0/1", n_err, n_end); end
    checks++; if (sp_n !== 7) begin failures++; $display("FAIL ls_nstb got=%0d exp=7", sp_n); end
    checks++; if (sp_min < 33 || sp_max > 34) begin failures++; $display("FAIL ls_spacing got=%0d..%0d exp=33..34", sp_min, sp_max); end
    set_line(S0);
    #200;
    iIS_FS = 1'b1; fs = 1'b1;
    #200;
    bit_ns = 1000.0 / 12.0;
    add_idle(4); play();
  endtask

  task automatic test_partial();
    clear_mon();
    add_sync(); add_byte(8'h3C, 1'b0);
    add_bit(1'b1, 1'b0); add_bit(1'b0, 1'b0); add_bit(1'b1, 1'b0);
    add_eop(); add_idle(4);
    play();
    checks++; if (got.size() !== 1 || got[0] !== 8'h3C) begin failures++; $display("FAIL part_byte got=%0d/%h exp=1/3c", got.size(), got[0]); end
    checks++; if (n_pair !== 1) begin failures++; $display("FAIL part_pair got=%0d exp=1", n_pair); end
    checks++; if (n_end !== 1 || n_err !== 1) begin failures++; $display("FAIL part_counts got end=%0d err=%0d exp 1/1", n_end, n_err); end
    checks++; if (oByte_cnt !== 7'd1) begin failures++; $display("FAIL part_cnt got=%0d exp=1", oByte_cnt); end
  endtask

  task automatic test_sync_err();
    clear_mon();
    lvl = 1'b1;
    for (int i = 0; i < 4; i++) add_nrzi(1'b0);
    sym.push_back(S0); sym.push_back(S0); sym.push_back(S0);
    add_idle(3);
    play();
    checks++; if (n_err !== 1 || n_start !== 0) begin failures++; $display("FAIL syncerr got err=%0d start=%0d exp 1/0", n_err, n_start); end
    checks++; if (oState !== 3'd0) begin failures++; $display("FAIL syncerr_idle got=%0d exp=0", oState); end
    clear_mon();
    add_sync(); add_byte(8'h11, 1'b0); add_eop(); add_idle(4);
    play();
    checks++; if (got.size() !== 1 || got[0] !== 8'h11) begin failures++; $display("FAIL syncerr_next got=%0d/%h exp=1/11", got.size(), got[0]); end
    checks++; if (n_start !== 1 || n_err !== 0) begin failures++; $display("FAIL syncerr_flags got start=%0d err=%0d exp 1/0", n_start, n_err); end
  endtask

  task automatic test_reset_mid();
    add_sync(); add_byte(8'h77, 1'b0); add_idle(3);
    play();
    checks++; if (oState !== 3'd2) begin failures++; $display("FAIL rstmid_pre got=%0d exp=2", oState); end
    iRSTN = 1'b0;
    #1;
    checks++; if (oState !== 3'd0 || oData !== 64'd0) begin failures++; $display("FAIL rstmid_clear got state=%0d data=%h exp 0/0", oState, oData); end
    checks++; if ({oByte, oByte_cnt} !== 15'd0) begin failures++; $display("FAIL rstmid_byte got=%h/%0d exp=0/0", oByte, oByte_cnt); end
    #60;
    iRSTN = 1'b1;
    add_idle(4); play();
    clear_mon();
    add_sync(); add_byte(8'h5A, 1'b0); add_eop(); add_idle(4);
    play();
    checks++; if (got.size() !== 1 || got[0] !== 8'h5A) begin failures++; $display("FAIL rstmid_next got=%0d/%h exp=1/5a", got.size(), got[0]); end
    checks++; if (oData !== 64'h5A) begin failures++; $display("FAIL rstmid_data got=%h exp=5a", oData); end
    checks++; if (n_err !== 0 || n_end !== 1) begin failures++; $display("FAIL rstmid_flags got err=%0d end=%0d exp 0/1", n_err, n_end); end
  endtask

  task automatic test_skew(input real factor);
    logic [7:0] pkt [10];
    int bad;
    pkt = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hFF, 8'h00};
    bit_ns = factor * 1000.0 / 12.0;
    clear_mon();
    add_sync();
    for (int i = 0; i < 10; i++) add_byte(pkt[i], 1'b0);
    add_eop(); add_idle(4);
    play();
    bad = 0;
    for (int i = 0; i < 10; i++) if (got[i] !== pkt[i]) bad++;
    checks++; if (got.size() !== 10 || bad !== 0) begin failures++; $display("FAIL skew_bytes x%0.2f got n=%0d bad=%0d exp 10/0", factor, got.size(), bad); end
    checks++; if (oData !== 64'h456789ABCDEFFF00) begin failures++; $display("FAIL skew_data got=%h exp=456789abcdefff00", oData); end
    checks++; if (oByte_cnt !== 7'd10 || n_err !== 0) begin failures++; $display("FAIL skew_cnt got=%0d err=%0d exp 10/0", oByte_cnt, n_err); end
    bit_ns = 1000.0 / 12.0;
  endtask

  initial begin
    fs = 1'b1;
    iIS_FS = 1'b1;
    bit_ns = 1000.0 / 12.0;
    n_overlap = 0;
    clear_mon();
    test_reset();
    test_fs_basic();
    test_stuff();
    test_low_speed();
    test_partial();
    test_sync_err();
    test_reset_mid();
    test_skew(1.01);
    test_skew(0.99);
    checks++; if (n_overlap !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", n_overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
